// File: rtl/link_pkg.sv
// Shared handshake definitions for the link master and slave FSMs.
// Holds the state encoding and the width of the ack-hold down-counter.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2,
        HOLD  = 2'd3
    } link_state_t;

    localparam int ACK_CNT_W = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// Storage is deliberately left unreset; only pointers and level are cleared.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/link_slave_fifo.sv
// 4-phase handshake slave that captures each transfer into a receive FIFO.
// Ack is held for at least ACK_HOLD cycles; early req release flags proto_err.
module link_slave_fifo
    import link_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int ACK_HOLD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [DATA_W-1:0]          last_byte,
    output logic [15:0]                rx_count,
    input  logic                       err_clr,
    output logic                       proto_err
);

    link_state_t          state;
    link_state_t          state_nxt;
    logic [ACK_CNT_W-1:0] hold_cnt;
    logic [ACK_CNT_W-1:0] hold_cnt_nxt;
    logic                 capture;
    logic                 err_set;
    logic                 fifo_full;
    logic                 fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (rd_en),
        .din   (data_in),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign full     = fifo_full;
    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ack      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            ack      <= (state_nxt == ACK) || (state_nxt == HOLD);
        end
    end

    // Capture is gated by the registered full, so a same-edge pop cannot open a slot.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        capture      = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE, STALL: begin
                if (req && !fifo_full) begin
                    capture      = 1'b1;
                    state_nxt    = ACK;
                    hold_cnt_nxt = ACK_CNT_W'(ACK_HOLD - 1);
                end else if (req) begin
                    state_nxt = STALL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                if (!req) begin
                    err_set = 1'b1;
                end
                if (hold_cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new error wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte <= '0;
            rx_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (capture) begin
                last_byte <= data_in;
                rx_count  <= rx_count + 16'd1;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_link_slave_fifo.sv
// Self-checking bench: directed handshake scenarios plus randomized traffic,
// compared each cycle against a queue-based transfer model.
module tb_link_slave_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int ACK_HOLD = 3;
    localparam int LVL_W    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [DATA_W-1:0] data_in;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] last_byte;
    logic [15:0]       rx_count;
    logic              err_clr;
    logic              proto_err;

    int vec_count   = 0;
    int miscompares = 0;

    // Reference model: a transfer is either in progress or not; while in
    // progress, ack stays high, the first ACK_HOLD cycles demand req high.
    logic [DATA_W-1:0] m_q[$];
    logic              m_in_xfer;
    int                m_ack_left;
    logic [DATA_W-1:0] m_last;
    logic [15:0]       m_rx;
    logic              m_err;

    link_slave_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ACK_HOLD (ACK_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .level     (level),
        .last_byte (last_byte),
        .rx_count  (rx_count),
        .err_clr   (err_clr),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_in_xfer  = 1'b0;
        m_ack_left = 0;
        m_last     = '0;
        m_rx       = '0;
        m_err      = 1'b0;
    endtask

    task automatic modelEdge();
        logic was_full;
        logic do_pop;
        logic err_now;
        was_full = (m_q.size() == DEPTH);
        do_pop   = rd_en && (m_q.size() > 0);
        err_now  = 1'b0;
        if (do_pop) begin
            void'(m_q.pop_front());
        end
        if (!m_in_xfer) begin
            if (req && !was_full) begin
                m_q.push_back(data_in);
                m_last     = data_in;
                m_rx       = m_rx + 16'd1;
                m_in_xfer  = 1'b1;
                m_ack_left = ACK_HOLD;
            end
        end else if (m_ack_left > 0) begin
            if (!req) err_now = 1'b1;
            m_ack_left--;
        end else if (!req) begin
            m_in_xfer = 1'b0;
        end
        if (err_now) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("ack", ack, m_in_xfer);
        checkOutput("rd_valid", rd_valid, m_q.size() > 0);
        checkOutput("full", full, m_q.size() == DEPTH);
        checkOutput("level", level, m_q.size());
        checkOutput("last_byte", last_byte, m_last);
        checkOutput("rx_count", rx_count, m_rx);
        checkOutput("proto_err", proto_err, m_err);
        if (m_q.size() > 0) checkOutput("rd_data", rd_data, m_q[0]);
    endtask

    task automatic applyStimulus(input logic r, input logic [DATA_W-1:0] d,
                                 input logic rd, input logic ec);
        req     = r;
        data_in = d;
        rd_en   = rd;
        err_clr = ec;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic doTransfer(input logic [DATA_W-1:0] d, input logic rd);
        int n;
        n = 0;
        applyStimulus(1'b1, d, rd, 1'b0);
        while (!ack && n < 20) begin
            applyStimulus(1'b1, d, 1'b0, 1'b0);
            n++;
        end
        checkOutput("xfer_ack_rise", ack, 1'b1);
        repeat (ACK_HOLD) applyStimulus(1'b1, d, 1'b0, 1'b0);
        n = 0;
        while (ack && n < 20) begin
            applyStimulus(1'b0, d, 1'b0, 1'b0);
            n++;
        end
        checkOutput("xfer_ack_fall", ack, 1'b0);
    endtask

    initial begin
        rst     = 1'b0;
        req     = 1'b0;
        data_in = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        modelReset();
        #2;

        // Basic capture of 0xA5
        doReset();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("t36_ack", ack, 1'b1);
        checkOutput("t36_rd_data", rd_data, 8'hA5);
        checkOutput("t36_level", level, 1);
        checkOutput("t36_last", last_byte, 8'hA5);
        checkOutput("t36_rx", rx_count, 1);
        repeat (ACK_HOLD) applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("t36_hold_ack", ack, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t36_ack_fall", ack, 1'b0);

        // Fill, stall on the fifth word, pop once, then capture
        doReset();
        doTransfer(8'h11, 1'b0);
        doTransfer(8'h22, 1'b0);
        doTransfer(8'h33, 1'b0);
        doTransfer(8'h44, 1'b0);
        checkOutput("t37_full", full, 1'b1);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("t37_stall_ack", ack, 1'b0);
        checkOutput("t37_stall_level", level, 4);
        checkOutput("t37_head", rd_data, 8'h11);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("t37_pop_no_push", level, 3);
        checkOutput("t37_pop_ack", ack, 1'b0);
        checkOutput("t37_new_head", rd_data, 8'h22);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("t37_cap_ack", ack, 1'b1);
        checkOutput("t37_cap_level", level, 4);
        checkOutput("t37_cap_last", last_byte, 8'h55);
        repeat (ACK_HOLD) applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Early req drop sets proto_err, clear, then clear colliding with a new error
        doReset();
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t38_err", proto_err, 1'b1);
        checkOutput("t38_ack_kept", ack, 1'b1);
        repeat (ACK_HOLD - 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t38_ack_hold", ack, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t38_ack_fall", ack, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t38_err_clr", proto_err, 1'b0);
        applyStimulus(1'b1, 8'h67, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t26_err_wins", proto_err, 1'b1);
        repeat (ACK_HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Capture coinciding with a pop at level 2
        doReset();
        doTransfer(8'h10, 1'b0);
        doTransfer(8'h20, 1'b0);
        doTransfer(8'h30, 1'b1);
        checkOutput("t39_level", level, 2);
        checkOutput("t39_head", rd_data, 8'h20);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t39_order", rd_data, 8'h30);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t28_empty_pop", level, 0);

        // Asynchronous reset mid-ACK with req held across release
        doReset();
        doTransfer(8'h01, 1'b0);
        doTransfer(8'h02, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        checkOutput("t40_pre_level", level, 3);
        rst = 1'b1;
        #1;
        checkOutput("t40_async_ack", ack, 1'b0);
        checkOutput("t40_async_level", level, 0);
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
        checkOutput("t40_recapture", ack, 1'b1);
        checkOutput("t40_rx", rx_count, 1);
        repeat (ACK_HOLD) applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // rx_count wrap from a preloaded 0xFFFF
        doReset();
        force dut.rx_count = 16'hFFFF;
        #1;
        release dut.rx_count;
        m_rx = 16'hFFFF;
        doTransfer(8'h99, 1'b0);
        checkOutput("t41_wrap", rx_count, 16'h0000);

        // Randomized traffic
        doReset();
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, DATA_W'($urandom),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
